booth_mul_arbiter: RTL and testbench
====================================

Name: booth_mul_arbiter

Overview:
Shares one combinational 8x8 signed Booth multiplier (Booth encoder plus four-partial-product sum tree, 16-bit product) between two requesters, e.g. the calculator ALU and the sequencer.
- Arbitrates round-robin and registers the operands onto the multiplier inputs.
- Waits a programmable number of cycles for the adder tree to settle, then captures the 16-bit product.
- Returns the product to the winning requester through a valid/ready handshake.

Parameters:
MUL_LAT, 2, cycles operands are held before the product is sampled. Legal range 1..15.

Ports:
clk  input  1  clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
req0_valid  input  1  requester 0 has an operand pair
req0_ready  output  1  requester 0 operands accepted this cycle
req0_a  input  8  requester 0 multiplicand, two's complement
req0_b  input  8  requester 0 multiplier, two's complement
req1_valid  input  1  requester 1 has an operand pair
req1_ready  output  1  requester 1 operands accepted this cycle
req1_a  input  8  requester 1 multiplicand
req1_b  input  8  requester 1 multiplier
rsp0_valid  output  1  product available for requester 0
rsp0_ready  input  1  requester 0 takes product
rsp1_valid  output  1  product available for requester 1
rsp1_ready  input  1  requester 1 takes product
rsp_data  output  16  signed product, shared by both response channels
mul_a  output  8  registered operand to multiplier
mul_b  output  8  registered operand to multiplier
mul_p  input  16  combinational product from multiplier
busy  output  1  high in any state other than IDLE

Behaviour:
- Reset values:
  - All registered outputs are 0: mul_a, mul_b, rsp_data, rspN_valid, busy.
  - State is IDLE, wait counter is 0.
  - last_grant is 1, so requester 0 wins the first tie.
- States: IDLE, EXEC, RESP.
- IDLE:
  - reqN_ready is combinational: IDLE && reqN_valid && (other not valid || last_grant != N).
  - At most one ready is high at a time.
  - On a handshake in cycle T: latch reqN_a/b into mul_a/mul_b, record owner=N, load counter with MUL_LAT-1, go to EXEC.
- EXEC:
  - mul_a/mul_b are held stable.
  - The counter decrements each cycle. When it reaches 0, capture mul_p into rsp_data and go to RESP.
  - EXEC lasts exactly MUL_LAT cycles.
- RESP:
  - rsp<owner>_valid is high; the other rsp valid stays 0.
  - rsp_data and mul_a/mul_b are held until rsp<owner>_ready.
  - On the handshake cycle: drop valid, set last_grant=owner, return to IDLE.
  - The next request can be accepted in the following cycle, never in the same cycle.
- Latency: accept at T, mul_a valid from T+1, rspN_valid first high at T+1+MUL_LAT.
- Arithmetic:
  - The product is passed through unmodified; no saturation or rounding.
  - -128*-128 = 16384 (0x4000) is representable.
- Requester rule: reqN_a/b are held stable while reqN_valid is high. A request withdrawn before ready is simply not served.
- Busy: no request is accepted while EXEC or RESP is active; reqN_ready stays 0.
- Response ready: rspN_ready asserted outside RESP, or for the non-owner, is ignored.
- Reset mid-operation:
  - The asynchronous reset aborts immediately and all outputs take their reset values.
  - The in-flight result is discarded and no response is issued.
- Illegal parameter: MUL_LAT=0 or >15 triggers a simulation error at elaboration.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined: at acceptance, if a==0 or b==0, skip EXEC. Load rsp_data=0 and enter RESP directly, so rspN_valid is high at T+1. mul_a/mul_b are still loaded.
- Undefined: zero operands take the full MUL_LAT path like any other pair.

Test Plan:
1. MUL_LAT=2, req0 a=0x07 b=0xFD -> req0_ready at T; rsp0_valid at T+3; rsp_data=0xFFEB (-21); rsp1_valid stays 0.
2. Both valid from reset: req0 a=5 b=6, req1 a=0x80 b=0x80, rsp ready held high -> req0 served first with 0x001E, then req1 with 0x4000. A following tie goes to req0 again.
3. req1 a=0x80 b=0x7F, rsp1_ready low for 4 cycles -> rsp1_valid and rsp_data=0xC080 held, mul_a/mul_b stable, req0_ready stays 0. Release ready -> IDLE the next cycle.
4. Assert rst_n low during the second EXEC cycle -> all outputs 0 immediately and no response ever appears. A new req0 a=3 b=3 after reset -> 0x0009 at T+3.
5. req0 a=0x00 b=0xB3 with MUL_LAT=4 -> macro defined: rsp0_valid at T+1, data 0x0000. Macro undefined: rsp0_valid at T+5, data 0x0000.
6. MUL_LAT=1, back-to-back req1 pairs (-1*-1, 127*127), rsp1_ready always high -> results 0x0001 then 0x3F01, with accepts 3 cycles apart.

Source files
------------

// File: rtl/booth_mul_arbiter.sv
// Round-robin arbiter sharing one external combinational 8x8 signed multiplier between two requesters.
// Optional MUL_ZERO_BYPASS_EN: zero operands skip the settle wait and respond with 0 one cycle after accept.
module booth_mul_arbiter #(
  parameter int unsigned MUL_LAT = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [7:0]  req0_a,
  input  logic [7:0]  req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [7:0]  req1_a,
  input  logic [7:0]  req1_b,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [15:0] rsp_data,
  output logic [7:0]  mul_a,
  output logic [7:0]  mul_b,
  input  logic [15:0] mul_p,
  output logic        busy
);

  if (MUL_LAT < 1 || MUL_LAT > 15) begin : gen_lat_check
    $error("booth_mul_arbiter: MUL_LAT=%0d outside legal range 1..15", MUL_LAT);
  end

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic [7:0]  mul_a_q, mul_a_d;
  logic [7:0]  mul_b_q, mul_b_d;
  logic [15:0] rsp_q, rsp_d;

  logic       acc0, acc1;
  logic [7:0] sel_a, sel_b;
  logic       zero_ops;
  logic       rsp_taken;

  // A requester wins unless the other one also asks and this one was granted last.
  assign acc0 = (state_q == StIdle) && req0_valid && (!req1_valid || (last_q != 1'b0));
  assign acc1 = (state_q == StIdle) && req1_valid && (!req0_valid || (last_q != 1'b1));

  assign sel_a = acc1 ? req1_a : req0_a;
  assign sel_b = acc1 ? req1_b : req0_b;

`ifdef MUL_ZERO_BYPASS_EN
  assign zero_ops = (sel_a == 8'd0) || (sel_b == 8'd0);
`else
  assign zero_ops = 1'b0;
`endif

  assign rsp_taken = owner_q ? rsp1_ready : rsp0_ready;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    last_d  = last_q;
    mul_a_d = mul_a_q;
    mul_b_d = mul_b_q;
    rsp_d   = rsp_q;
    unique case (state_q)
      StIdle: begin
        if (acc0 || acc1) begin
          mul_a_d = sel_a;
          mul_b_d = sel_b;
          owner_d = acc1;
          if (zero_ops) begin
            rsp_d   = 16'd0;
            state_d = StResp;
          end else begin
            cnt_d   = 4'(MUL_LAT - 1);
            state_d = StExec;
          end
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          rsp_d   = mul_p;
          state_d = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (rsp_taken) begin
          last_d  = owner_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= 4'd0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      mul_a_q <= 8'd0;
      mul_b_q <= 8'd0;
      rsp_q   <= 16'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      mul_a_q <= mul_a_d;
      mul_b_q <= mul_b_d;
      rsp_q   <= rsp_d;
    end
  end

  assign req0_ready = acc0;
  assign req1_ready = acc1;
  assign rsp0_valid = (state_q == StResp) && !owner_q;
  assign rsp1_valid = (state_q == StResp) && owner_q;
  assign rsp_data   = rsp_q;
  assign mul_a      = mul_a_q;
  assign mul_b      = mul_b_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_booth_mul_arbiter.sv
// Bench for booth_mul_arbiter: directed vector table, arbitration/backpressure/reset sequences,
// and random transactions against a plain-arithmetic reference model.
module tb_booth_mul_arbiter;
  localparam int unsigned MUL_LAT = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rv[2];
  logic        rr[2];
  logic [7:0]  ra[2];
  logic [7:0]  rb[2];
  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid, busy;
  logic [15:0] rsp_data, mul_p;
  logic [7:0]  mul_a, mul_b;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int last_grant = 1;
  int acc_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Stand-in for the shared multiplier the block drives.
  assign mul_p = $signed({{8{mul_a[7]}}, mul_a}) * $signed({{8{mul_b[7]}}, mul_b});

  booth_mul_arbiter #(.MUL_LAT(MUL_LAT)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (rv[0]),
    .req0_ready (req0_ready),
    .req0_a     (ra[0]),
    .req0_b     (rb[0]),
    .req1_valid (rv[1]),
    .req1_ready (req1_ready),
    .req1_a     (ra[1]),
    .req1_b     (rb[1]),
    .rsp0_valid (rsp0_valid),
    .rsp0_ready (rr[0]),
    .rsp1_valid (rsp1_valid),
    .rsp1_ready (rr[1]),
    .rsp_data   (rsp_data),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_p      (mul_p),
    .busy       (busy)
  );

  typedef struct {
    int          n;
    logic [7:0]  a;
    logic [7:0]  b;
    int          hold;
    logic [15:0] exp;
  } vec_t;

  function automatic logic [15:0] ref_mul(input logic [7:0] a, input logic [7:0] b);
    int p;
    p = int'($signed(a)) * int'($signed(b));
    return p[15:0];
  endfunction

  function automatic int exp_lat(input logic [7:0] a, input logic [7:0] b);
`ifdef MUL_ZERO_BYPASS_EN
    if (a == 8'd0 || b == 8'd0) return 1;
`endif
    return 1 + int'(MUL_LAT);
  endfunction

  function automatic logic rdy(input int n);
    return (n == 1) ? req1_ready : req0_ready;
  endfunction

  function automatic logic rsv(input int n);
    return (n == 1) ? rsp1_valid : rsp0_valid;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic issue(input int n, input logic [7:0] a, input logic [7:0] b, input string name);
    ra[n] = a;
    rb[n] = b;
    rv[n] = 1'b1;
    #1;
    check({name, " ready"}, 32'(rdy(n)), 1);
    check({name, " other ready"}, 32'(rdy(1 - n)), 0);
    acc_cyc = cyc;
  endtask

  // Called in the accept cycle; follows the transaction to its response handshake and back to idle.
  task automatic wait_rsp(input int n, input logic [7:0] a, input logic [7:0] b, input int hold,
                          input logic [15:0] exp, input string name);
    int lat;
    bit got;
    lat = 1;
    got = 1'b0;
    @(negedge clk);
    rv[0] = 1'b0;
    rv[1] = 1'b0;
    rr[n] = (hold == 0);
    for (int i = 0; i < 40; i++) begin
      #1;
      if (rsv(n)) begin
        got = 1'b1;
        break;
      end
      check({name, " exec ops"}, {16'd0, mul_a, mul_b}, {16'd0, a, b});
      @(negedge clk);
      lat++;
    end
    check({name, " rsp seen"}, 32'(got), 1);
    if (got) begin
      check({name, " latency"}, lat, exp_lat(a, b));
      check({name, " data"}, {16'd0, rsp_data}, {16'd0, exp});
      check({name, " other valid"}, 32'(rsv(1 - n)), 0);
      for (int h = 0; h < hold; h++) begin
        rv[1 - n] = 1'b1;
        rr[1 - n] = 1'b1;
        #1;
        check({name, " held valid"}, 32'(rsv(n)), 1);
        check({name, " held data"}, {16'd0, rsp_data}, {16'd0, exp});
        check({name, " held ops"}, {16'd0, mul_a, mul_b}, {16'd0, a, b});
        check({name, " busy blocks"}, 32'(rdy(1 - n)), 0);
        @(negedge clk);
      end
      rr[n] = 1'b1;
      rv[1 - n] = 1'b0;
      rr[1 - n] = 1'b0;
      #1;
      check({name, " valid at take"}, 32'(rsv(n)), 1);
      @(negedge clk);
      rr[n] = 1'b0;
      #1;
      check({name, " idle after"}, {30'd0, busy, rsv(n)}, 0);
      last_grant = n;
    end
  endtask

  vec_t vecs[9];

  initial begin
    int prev_cyc;
    int cnt;
    int w;
    logic [7:0] a0, b0, a1, b1;

    vecs[0] = '{n: 0, a: 8'h07, b: 8'hFD, hold: 0, exp: 16'hFFEB};
    vecs[1] = '{n: 1, a: 8'h80, b: 8'h7F, hold: 4, exp: 16'hC080};
    vecs[2] = '{n: 0, a: 8'h00, b: 8'hB3, hold: 0, exp: 16'h0000};
    vecs[3] = '{n: 1, a: 8'hFF, b: 8'hFF, hold: 0, exp: 16'h0001};
    vecs[4] = '{n: 1, a: 8'h7F, b: 8'h7F, hold: 0, exp: 16'h3F01};
    vecs[5] = '{n: 0, a: 8'h80, b: 8'h80, hold: 1, exp: 16'h4000};
    vecs[6] = '{n: 0, a: 8'h7F, b: 8'h80, hold: 0, exp: 16'hC080};
    vecs[7] = '{n: 1, a: 8'h05, b: 8'h06, hold: 2, exp: 16'h001E};
    vecs[8] = '{n: 0, a: 8'h80, b: 8'h01, hold: 0, exp: 16'hFF80};

    for (int i = 0; i < 2; i++) begin
      rv[i] = 1'b0;
      rr[i] = 1'b0;
      ra[i] = 8'd0;
      rb[i] = 8'd0;
    end

    repeat (3) @(negedge clk);
    #1;
    check("reset mul_a", {24'd0, mul_a}, 0);
    check("reset mul_b", {24'd0, mul_b}, 0);
    check("reset rsp_data", {16'd0, rsp_data}, 0);
    check("reset valids", {30'd0, rsp0_valid, rsp1_valid}, 0);
    check("reset busy", 32'(busy), 0);
    rst_n = 1'b1;

    // Tie from reset goes to requester 0, then 1, then 0 again.
    ra[0] = 8'd5; rb[0] = 8'd6; rv[0] = 1'b1;
    ra[1] = 8'h80; rb[1] = 8'h80; rv[1] = 1'b1;
    #1;
    check("tie1 r0 ready", 32'(req0_ready), 1);
    check("tie1 r1 ready", 32'(req1_ready), 0);
    wait_rsp(0, 8'd5, 8'd6, 0, 16'h001E, "tie1");
    issue(1, 8'h80, 8'h80, "tie1 second");
    wait_rsp(1, 8'h80, 8'h80, 0, 16'h4000, "tie1 second");
    rv[0] = 1'b1; rv[1] = 1'b1;
    #1;
    check("tie2 r0 ready", 32'(req0_ready), 1);
    check("tie2 r1 ready", 32'(req1_ready), 0);
    wait_rsp(0, 8'd5, 8'd6, 0, 16'h001E, "tie2");

    // Directed vectors; accept spacing follows latency plus backpressure plus one idle cycle.
    prev_cyc = 0;
    for (int i = 0; i < 9; i++) begin
      issue(vecs[i].n, vecs[i].a, vecs[i].b, $sformatf("vec%0d", i));
      if (i > 0)
        check($sformatf("vec%0d spacing", i), acc_cyc - prev_cyc,
              exp_lat(vecs[i-1].a, vecs[i-1].b) + vecs[i-1].hold + 1);
      prev_cyc = acc_cyc;
      wait_rsp(vecs[i].n, vecs[i].a, vecs[i].b, vecs[i].hold, vecs[i].exp, $sformatf("vec%0d", i));
    end

    // Reset in the second execute cycle discards the in-flight result.
    issue(0, 8'd9, 8'd5, "rst pre");
    @(negedge clk);
    rv[0] = 1'b0;
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("rst mid ops", {16'd0, mul_a, mul_b}, 0);
    check("rst mid data", {16'd0, rsp_data}, 0);
    check("rst mid flags", {29'd0, busy, rsp0_valid, rsp1_valid}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_grant = 1;
    cnt = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      if (rsp0_valid || rsp1_valid) cnt++;
    end
    check("rst no rsp", cnt, 0);
    issue(0, 8'd3, 8'd3, "post rst");
    wait_rsp(0, 8'd3, 8'd3, 0, 16'h0009, "post rst");

    // Random transactions against the reference model, including ties.
    for (int i = 0; i < 40; i++) begin
      a0 = 8'($urandom); b0 = 8'($urandom);
      a1 = 8'($urandom); b1 = 8'($urandom);
      if ($urandom_range(0, 4) == 0) a0 = 8'd0;
      if ($urandom_range(0, 4) == 0) b1 = 8'd0;
      if ($urandom_range(0, 2) == 0) begin
        ra[0] = a0; rb[0] = b0; rv[0] = 1'b1;
        ra[1] = a1; rb[1] = b1; rv[1] = 1'b1;
        #1;
        w = (last_grant == 1) ? 0 : 1;
        check($sformatf("rnd%0d tie win", i), 32'(rdy(w)), 1);
        check($sformatf("rnd%0d tie lose", i), 32'(rdy(1 - w)), 0);
      end else begin
        w = int'($urandom_range(0, 1));
        issue(w, (w == 1) ? a1 : a0, (w == 1) ? b1 : b0, $sformatf("rnd%0d", i));
      end
      wait_rsp(w, (w == 1) ? a1 : a0, (w == 1) ? b1 : b0, int'($urandom_range(0, 2)),
               ref_mul((w == 1) ? a1 : a0, (w == 1) ? b1 : b0), $sformatf("rnd%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
